// File: rtl/local_ni_pkg.sv
// Shared types, flit geometry and flit packing helper for the local NI.
`include "global.vh"

package local_ni_pkg;

   localparam int unsigned CordW      = `CORD_WIDTH;
   localparam int unsigned DefCordX   = `CORD_X;
   localparam int unsigned DefCordY   = `CORD_Y;
   localparam int unsigned DataW      = `DATA_WIDTH;
   localparam int unsigned DstW       = `DST_WIDTH;
   localparam int unsigned SeqW       = `SEQ_WIDTH;
   localparam int unsigned PayloadW   = `PAYLOAD_WIDTH;
   localparam int unsigned VldPos     = `VLD_POS;
   localparam int unsigned DstPos     = `DST_POS;
   localparam int unsigned SrcPos     = `SRC_POS;
   localparam int unsigned SeqPos     = `SEQ_POS;
   localparam int unsigned PayloadPos = `PAYLOAD_POS;

   // Injection queue entry: what the core supplies per packet
   typedef struct packed {
      logic [DstW-1:0]     dst;
      logic [PayloadW-1:0] payload;
   } inj_entry_t;

   // Ejection queue entry: what the core sees per received flit
   typedef struct packed {
      logic [DstW-1:0]     src;
      logic [SeqW-1:0]     seq;
      logic [PayloadW-1:0] payload;
   } ej_entry_t;

   // Build a valid flit from its fields
   function automatic logic [DataW-1:0] pack_flit(input logic [DstW-1:0]     dst,
                                                  input logic [DstW-1:0]     src,
                                                  input logic [SeqW-1:0]     seq,
                                                  input logic [PayloadW-1:0] payload);
      logic [DataW-1:0] f;
      f                          = '0;
      f[VldPos]                  = 1'b1;
      f[DstPos +: DstW]          = dst;
      f[SrcPos +: DstW]          = src;
      f[SeqPos +: SeqW]          = seq;
      f[PayloadPos +: PayloadW]  = payload;
      return f;
   endfunction

endpackage

// File: rtl/local_ni_if.sv
// Core/router-facing signal bundle of the local NI.
interface local_ni_if;
   import local_ni_pkg::*;

   // TX (core -> router)
   logic                tx_valid;
   logic                tx_ready;
   logic [DstW-1:0]     tx_dst;
   logic [PayloadW-1:0] tx_payload;
   logic [DataW-1:0]    flit_inj;
   logic                inj_grant;
   logic                starve;

   // RX (router -> core)
   logic [DataW-1:0]    flit_ej;
   logic                rx_valid;
   logic                rx_ready;
   logic [DstW-1:0]     rx_src;
   logic [SeqW-1:0]     rx_seq;
   logic [PayloadW-1:0] rx_payload;
   logic [7:0]          drop_cnt;
   logic [7:0]          misroute_cnt;

   // NI side
   modport slave (
      input  tx_valid, tx_dst, tx_payload, inj_grant, flit_ej, rx_ready,
      output tx_ready, flit_inj, starve, rx_valid, rx_src, rx_seq, rx_payload,
             drop_cnt, misroute_cnt
   );

   // Core/router side
   modport master (
      output tx_valid, tx_dst, tx_payload, inj_grant, flit_ej, rx_ready,
      input  tx_ready, flit_inj, starve, rx_valid, rx_src, rx_seq, rx_payload,
             drop_cnt, misroute_cnt
   );
endinterface

// File: rtl/global.vh
// Global flit geometry shared by the router and its network interfaces.
`ifndef GLOBAL_VH
`define GLOBAL_VH

`define CORD_WIDTH    2
`define CORD_X        1
`define CORD_Y        2

`define DST_WIDTH     4
`define SEQ_WIDTH     8
`define PAYLOAD_WIDTH 8
`define DATA_WIDTH    25

// Flit layout, MSB to LSB: {vld, dst, src, seq, payload}
`define VLD_POS       24
`define DST_POS       20
`define SRC_POS       16
`define SEQ_POS       8
`define PAYLOAD_POS   0

`endif

// File: rtl/local_ni_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only if a pop frees a slot
// in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [PtrW:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Status, effective push/pop and pointer/count next state
   always_comb begin
      full    = (cnt_q == (PtrW+1)'(DEPTH));
      empty   = (cnt_q == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) wr_d = wr_q + PtrW'(1);
      if (do_pop)  rd_d = rd_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (PtrW+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (PtrW+1)'(1);
      dout = mem_q[rd_q];
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/local_ni.sv
// Local network interface on router port 4: injection queue with grant/starve
// tracking, and an always-accepting ejection queue with drop/misroute counters.
module local_ni
   import local_ni_pkg::*;
#(
   parameter int unsigned CORD_X       = DefCordX,
   parameter int unsigned CORD_Y       = DefCordY,
   parameter int unsigned INJ_DEPTH    = 4,
   parameter int unsigned EJ_DEPTH     = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic       clk,
   input logic       n_rst,
   local_ni_if.slave bus
);

   localparam int unsigned    StarveW = $clog2(STARVE_LIMIT + 1);
   localparam logic [DstW-1:0] MyAddr = {CORD_X[CordW-1:0], CORD_Y[CordW-1:0]};

   inj_entry_t inj_din, inj_dout;
   logic       inj_push, inj_pop, inj_full, inj_empty, inj_accept;

   ej_entry_t  ej_din, ej_dout;
   logic       ej_push, ej_pop, ej_full, ej_empty, ej_vld, ej_hit;

   logic [SeqW-1:0]    seq_q, seq_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic [7:0]         drop_q, drop_d, misroute_q, misroute_d;

   sync_fifo #(
      .WIDTH ($bits(inj_entry_t)),
      .DEPTH (INJ_DEPTH)
   ) u_inj_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (inj_push),
      .pop   (inj_pop),
      .din   (inj_din),
      .dout  (inj_dout),
      .full  (inj_full),
      .empty (inj_empty)
   );

   sync_fifo #(
      .WIDTH ($bits(ej_entry_t)),
      .DEPTH (EJ_DEPTH)
   ) u_ej_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (ej_push),
      .pop   (ej_pop),
      .din   (ej_din),
      .dout  (ej_dout),
      .full  (ej_full),
      .empty (ej_empty)
   );

   // TX: enqueue from core, present head flit, sequence and starve tracking
   always_comb begin
      inj_din      = '{dst: bus.tx_dst, payload: bus.tx_payload};
      bus.tx_ready = !inj_full;
      // A same-cycle grant never makes room for a push into a full queue
      inj_push     = bus.tx_valid && !inj_full;
      inj_accept   = !inj_empty && bus.inj_grant;
      inj_pop      = inj_accept;

      seq_d = seq_q;
      if (inj_accept) seq_d = seq_q + 8'd1;

      starve_d = starve_q;
      if (inj_empty || inj_accept) begin
         starve_d = '0;
      end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
         starve_d = starve_q + StarveW'(1);
      end

      bus.flit_inj = inj_empty ? '0 : pack_flit(inj_dout.dst, MyAddr, seq_q, inj_dout.payload);
      bus.starve   = (starve_q == StarveW'(STARVE_LIMIT));
   end

   // RX: classify ejected flit, enqueue or count it, expose head to core
   always_comb begin
      ej_vld  = bus.flit_ej[VldPos];
      ej_hit  = (bus.flit_ej[DstPos +: DstW] == MyAddr);
      ej_din  = '{src:     bus.flit_ej[SrcPos +: DstW],
                  seq:     bus.flit_ej[SeqPos +: SeqW],
                  payload: bus.flit_ej[PayloadPos +: PayloadW]};
      ej_pop  = !ej_empty && bus.rx_ready;
      // The router cannot be stalled, so a core pop this cycle frees room for the arrival
      ej_push = ej_vld && ej_hit && (!ej_full || ej_pop);

      drop_d = drop_q;
      if (ej_vld && ej_hit && !ej_push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

      misroute_d = misroute_q;
      if (ej_vld && !ej_hit && misroute_q != 8'hFF) misroute_d = misroute_q + 8'd1;

      bus.rx_valid     = !ej_empty;
      bus.rx_src       = ej_dout.src;
      bus.rx_seq       = ej_dout.seq;
      bus.rx_payload   = ej_dout.payload;
      bus.drop_cnt     = drop_q;
      bus.misroute_cnt = misroute_q;
   end

   // Sequence, starve and error counter registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         seq_q      <= '0;
         starve_q   <= '0;
         drop_q     <= '0;
         misroute_q <= '0;
      end else begin
         seq_q      <= seq_d;
         starve_q   <= starve_d;
         drop_q     <= drop_d;
         misroute_q <= misroute_d;
      end
   end

endmodule

// File: tb/tb_local_ni.sv
// Directed bench for local_ni at node (1,2) with a cycle-level scoreboard.
module tb_local_ni;
   import local_ni_pkg::*;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   local_ni_if bus ();

   local_ni #(
      .CORD_X       (1),
      .CORD_Y       (2),
      .INJ_DEPTH    (4),
      .EJ_DEPTH     (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   localparam logic [3:0] Me = 4'b01_10;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard state
   logic [11:0] inj_q[$];  // {dst, payload}
   logic [19:0] ej_q[$];   // {src, seq, payload}
   logic [7:0]  m_seq;
   int          m_starve, m_drop, m_mis;

   function automatic logic [24:0] mk(input logic [3:0] dst, input logic [3:0] src,
                                      input logic [7:0] seq, input logic [7:0] pl);
      return {1'b1, dst, src, seq, pl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      inj_q.delete();
      ej_q.delete();
      m_seq    = 8'd0;
      m_starve = 0;
      m_drop   = 0;
      m_mis    = 0;
   endtask

   // One clock edge with current inputs, scoreboard update, then full output check
   task automatic cycle();
      bit          tx_push, acc, was_empty, rx_pop, vld, hit, rx_push;
      logic [11:0] tx_ent;
      logic [19:0] rx_ent;
      tx_push   = bus.tx_valid && (inj_q.size() < 4);
      acc       = bus.inj_grant && (inj_q.size() > 0);
      was_empty = (inj_q.size() == 0);
      tx_ent    = {bus.tx_dst, bus.tx_payload};
      rx_pop    = bus.rx_ready && (ej_q.size() > 0);
      vld       = bus.flit_ej[24];
      hit       = (bus.flit_ej[23:20] == Me);
      rx_push   = vld && hit && ((ej_q.size() < 4) || rx_pop);
      rx_ent    = bus.flit_ej[19:0];
      step();
      if (acc) begin
         void'(inj_q.pop_front());
         m_seq = m_seq + 8'd1;
      end
      if (tx_push) inj_q.push_back(tx_ent);
      if (was_empty || acc) m_starve = 0;
      else if (m_starve < 8) m_starve++;
      if (rx_pop) void'(ej_q.pop_front());
      if (rx_push) ej_q.push_back(rx_ent);
      if (vld && hit && !rx_push && m_drop < 255) m_drop++;
      if (vld && !hit && m_mis < 255) m_mis++;

      chk("tx_ready", bus.tx_ready, inj_q.size() < 4);
      if (inj_q.size() > 0)
         chk("flit_inj", bus.flit_inj, mk(inj_q[0][11:8], Me, m_seq, inj_q[0][7:0]));
      else
         chk("flit_inj_idle", bus.flit_inj, 0);
      chk("starve", bus.starve, m_starve == 8);
      chk("rx_valid", bus.rx_valid, ej_q.size() > 0);
      if (ej_q.size() > 0) chk("rx_head", {bus.rx_src, bus.rx_seq, bus.rx_payload}, ej_q[0]);
      chk("drop_cnt", bus.drop_cnt, m_drop);
      chk("misroute_cnt", bus.misroute_cnt, m_mis);
   endtask

   initial begin
      n_rst         = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_dst    = '0;
      bus.tx_payload = '0;
      bus.inj_grant = 1'b0;
      bus.flit_ej   = '0;
      bus.rx_ready  = 1'b0;
      model_reset();
      step();
      step();
      n_rst = 1'b1;

      // Reset state
      chk("rst_flit_inj", bus.flit_inj, 0);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_starve", bus.starve, 0);
      chk("rst_tx_ready", bus.tx_ready, 1);
      chk("rst_drop", bus.drop_cnt, 0);
      chk("rst_misroute", bus.misroute_cnt, 0);

      // Single packet with grant held high
      bus.tx_valid   = 1'b1;
      bus.tx_dst     = 4'b10_11;
      bus.tx_payload = 8'hAB;
      bus.inj_grant  = 1'b1;
      cycle();
      bus.tx_valid = 1'b0;
      chk("t1_flit", bus.flit_inj, 25'h1B600AB);
      cycle();
      chk("t1_gone", bus.flit_inj, 0);

      // Starvation: hold one flit ungranted, then grant
      bus.inj_grant  = 1'b0;
      bus.tx_valid   = 1'b1;
      bus.tx_dst     = 4'b11_00;
      bus.tx_payload = 8'h11;
      cycle();
      bus.tx_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         cycle();
         chk("starve_seq", bus.starve, (k >= 8) ? 1 : 0);
         chk("starve_hold", bus.flit_inj, mk(4'b11_00, Me, 8'd1, 8'h11));
      end
      bus.inj_grant = 1'b1;
      cycle();
      chk("starve_clear", bus.starve, 0);
      bus.inj_grant = 1'b0;

      // Fill injection queue; fifth packet must be held off
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.tx_dst     = 4'(i);
         bus.tx_payload = 8'h20 + 8'(i);
         cycle();
      end
      chk("inj_full_ready", bus.tx_ready, 0);
      bus.tx_dst     = 4'hF;
      bus.tx_payload = 8'h55;
      cycle();
      cycle();

      // Drain and stream through the sequence wrap
      bus.inj_grant = 1'b1;
      cycle();
      cycle();
      for (int i = 0; i < 262; i++) begin
         bus.tx_dst     = 4'(i);
         bus.tx_payload = 8'(i);
         cycle();
         if (m_seq == 8'd0 && inj_q.size() > 0) chk("seq_wrap", bus.flit_inj[15:8], 0);
      end
      bus.tx_valid = 1'b0;
      repeat (6) cycle();
      bus.inj_grant = 1'b0;

      // Six ejected flits with no core pops: four kept, two dropped
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.flit_ej = mk(Me, 4'h3, 8'h40 + 8'(i), 8'h90 + 8'(i));
         cycle();
      end
      bus.flit_ej = '0;
      chk("drop_six", bus.drop_cnt, 2);

      // Full queue, pop and arrival in the same cycle: arrival accepted
      bus.rx_ready = 1'b1;
      bus.flit_ej  = mk(Me, 4'h9, 8'h77, 8'hEE);
      cycle();
      bus.rx_ready = 1'b0;
      bus.flit_ej  = '0;
      chk("full_pop_push_drop", bus.drop_cnt, 2);

      // Misrouted flit and invalid flit
      bus.flit_ej = mk(4'h0, 4'h5, 8'h01, 8'h02);
      cycle();
      chk("misroute_one", bus.misroute_cnt, 1);
      bus.flit_ej = {1'b0, Me, 4'h5, 8'h03, 8'h04};
      cycle();
      bus.flit_ej = '0;

      // Drain in FIFO order
      bus.rx_ready = 1'b1;
      repeat (5) cycle();
      chk("rx_drained", bus.rx_valid, 0);
      bus.rx_ready = 1'b0;

      // Mid-operation reset with three entries in each queue
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.tx_dst     = 4'(i + 5);
         bus.tx_payload = 8'hC0 + 8'(i);
         bus.flit_ej    = mk(Me, 4'h1, 8'(i), 8'hD0 + 8'(i));
         cycle();
      end
      bus.tx_valid = 1'b0;
      bus.flit_ej  = '0;
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      model_reset();
      chk("mrst_flit_inj", bus.flit_inj, 0);
      chk("mrst_rx_valid", bus.rx_valid, 0);
      chk("mrst_drop", bus.drop_cnt, 0);
      chk("mrst_misroute", bus.misroute_cnt, 0);
      chk("mrst_tx_ready", bus.tx_ready, 1);
      chk("mrst_starve", bus.starve, 0);
      bus.inj_grant = 1'b1;
      bus.rx_ready  = 1'b1;
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
